// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: op encodings,
// FSM state encoding and the most-negative-value helper.
package muldiv_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns the two's-complement most-negative value of an xlen-bit word,
  // right-aligned in a MAX_XLEN-bit container; callers truncate to their width.
  function automatic logic [MAX_XLEN-1:0] most_neg(input int xlen);
    return MAX_XLEN'(1) << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator pair: shift-add for
// multiply, restoring shift-subtract for divide. Operands are magnitudes.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    rem_sh = {hi_i, lo_i[XLEN-1]};
    // The partial remainder is always below 2*divisor, so diff's top bit is
    // exactly the borrow that decides restore vs. keep.
    diff   = rem_sh - {1'b0, b_i};
    if (is_div_i) begin
      if (diff[XLEN]) begin
        hi_o = rem_sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end else begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN CALC cycles of radix-2 steps on
// operand magnitudes, then sign correction and a one-cycle result strobe.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            ip_clk,
  input  logic            ip_rst_n,
  input  logic            ip_valid,
  input  logic [2:0]      ip_op,
  input  logic [XLEN-1:0] ip_rs1,
  input  logic [XLEN-1:0] ip_rs2,
  input  logic            ip_flush,
  output logic            op_ready,
  output logic            op_valid,
  output logic [XLEN-1:0] op_result,
  output logic            op_div_zero,
  output logic [1:0]      op_dbg_state
);

  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

  // Handshake: a request transfers on a rising edge where ip_valid && op_ready
  // (and no ip_flush); op_valid is a single-cycle strobe with no backpressure.

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic            div_zero_q, div_zero_d, ovf_q, ovf_d;

  op_e             req_op;
  logic            req_is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] step_hi, step_lo;
  logic            calc_is_div;

  always_comb begin
    req_op     = op_e'(ip_op);
    req_is_div = req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_signed   = req_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed   = req_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg      = a_signed && ip_rs1[XLEN-1];
    b_neg      = b_signed && ip_rs2[XLEN-1];
    mag_a      = a_neg ? -ip_rs1 : ip_rs1;
    mag_b      = b_neg ? -ip_rs2 : ip_rs2;
  end

  assign calc_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (calc_is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (ip_valid && !ip_flush) begin
          state_d    = ST_CALC;
          cnt_d      = CNT_W'(XLEN);
          op_d       = req_op;
          hi_d       = '0;
          // Divide shifts the dividend out of lo; multiply shifts the multiplier.
          lo_d       = req_is_div ? mag_a : mag_b;
          b_d        = req_is_div ? mag_b : mag_a;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = req_is_div && (ip_rs2 == '0);
          ovf_d      = req_is_div && b_signed && (ip_rs1 == MOST_NEG) && (ip_rs2 == '1);
        end
      end
      ST_CALC: begin
        if (ip_flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (!ip_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    quot_fix = neg_res_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
  end

  assign op_ready     = ip_rst_n && (state_q == ST_IDLE);
  assign op_valid     = ip_rst_n && (state_q == ST_DONE) && !ip_flush;
  assign op_div_zero  = op_valid && div_zero_q;
  assign op_dbg_state = state_q;

  always_comb begin
    op_result = '0;
    if (op_valid) begin
      case (op_q)
        OP_MUL:                       op_result = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: op_result = prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              op_result = div_zero_q ? '1 : (ovf_q ? MOST_NEG : quot_fix);
        OP_REM, OP_REMU:              op_result = ovf_q ? '0 : rem_fix;
        default:                      op_result = '0;
      endcase
    end
  end

endmodule
